// File: rtl/pulse_train_gen.sv
// pulse_train_gen: emits a programmed number of single-cycle o_inc pulses
// separated by a programmed gap, then a one-cycle o_done strobe.
// Optional feature macro: ABORT_TRAIN_EN adds the i_abort input, which
// cancels a running train without a done strobe.
// Request protocol: i_start is a level request sampled only while idle; an
// accepted request latches i_num and i_gap. There is no backpressure and
// requests made while busy are dropped, not queued.
// All outputs, including the debug state, are driven straight from flops.
module pulse_train_gen #(
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_num,
  input  logic [GAP_W-1:0] i_gap,
`ifdef ABORT_TRAIN_EN
  input  logic             i_abort,
`endif
  output logic             o_inc,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_sent,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_num;
  logic [GAP_W-1:0]   r_g;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [CNT_W-1:0]   r_sent;
  logic               r_inc;
  logic               r_busy;
  logic               r_done;
  logic [GAP_W-1:0]   w_g_eff;
  logic [CNT_W-1:0]   w_sent_inc;
  logic               w_last;
  logic               w_abort;

`ifdef ABORT_TRAIN_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  // A zero gap is stretched to one so pulses can never touch.
  assign w_g_eff    = (i_gap == '0) ? GAP_W'(1) : i_gap;
  // sent never exceeds the latched count, so this increment cannot wrap.
  assign w_sent_inc = r_sent + CNT_W'(1);
  assign w_last     = (w_sent_inc == r_num);

  // Next-state decode; abort only has an effect while a train is running.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = (i_num != '0) ? S_PULSE : S_DONE;
        end
      end
      S_PULSE: begin
        if (w_abort)     w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_DONE;
        else             w_state_nxt = S_GAP;
      end
      S_GAP: begin
        if (w_abort)                       w_state_nxt = S_IDLE;
        else if (r_gap_cnt == GAP_W'(1))   w_state_nxt = S_PULSE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register plus outputs registered from the next state, so each
  // output is valid in the same cycle the FSM occupies the matching state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_inc   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_inc   <= (w_state_nxt == S_PULSE);
      r_busy  <= (w_state_nxt == S_PULSE) || (w_state_nxt == S_GAP);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // Datapath: latch the request, count pulses, and run the gap counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_num     <= '0;
      r_g       <= '0;
      r_gap_cnt <= '0;
      r_sent    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_num  <= i_num;
            r_g    <= w_g_eff;
            r_sent <= '0;
          end
        end
        S_PULSE: begin
          // A pulse ending on an abort edge still counts as sent.
          r_sent    <= w_sent_inc;
          r_gap_cnt <= r_g;
        end
        S_GAP: begin
          r_gap_cnt <= r_gap_cnt - GAP_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign o_inc       = r_inc;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_sent      = r_sent;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen: directed trains with hand-derived pulse/done cycles.
// The driver pushes every expected inc/done event (with its absolute cycle
// number and the sent/busy values it must show) into exp_q; a monitor pops
// and compares whenever the DUT raises o_inc or o_done.
module tb_pulse_train_gen;

  localparam int EW = 23; // {done, inc, cycle[15:0], sent[3:0], busy}

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] num;
  logic [3:0] gap;
`ifdef ABORT_TRAIN_EN
  logic       abort;
`endif
  logic       o_inc;
  logic       o_busy;
  logic       o_done;
  logic [3:0] o_sent;
  logic [1:0] o_dbg_state;

  always #5 clk = ~clk;

  logic [15:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  pulse_train_gen #(.CNT_W(4), .GAP_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (start),
    .i_num      (num),
    .i_gap      (gap),
`ifdef ABORT_TRAIN_EN
    .i_abort    (abort),
`endif
    .o_inc      (o_inc),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_sent     (o_sent),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: compares every inc/done event against the queue head.
  always @(negedge clk) begin
    logic [EW-1:0] act;
    if (o_busy === 1'b1) busy_cnt++;
    if (o_inc === 1'b1 || o_done === 1'b1) begin
      act = {o_done, o_inc, cyc, o_sent, o_busy};
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got 0x%0h expected no event (cycle %0d)", act, cyc);
      end else begin
        check("event", 32'(act), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  // n/gv: request; sp: cycle in which a stray start is pulsed (0 = none);
  // cut: cycle in which reset or abort is asserted (0 = run to completion).
  task automatic run_train(input int n, input int gv, input int sp,
                           input int cut, input bit cut_abort);
    int  g;
    int  e0;
    int  pc;
    int  n_exp;
    bit  timed_out;
    g = (gv == 0) ? 1 : gv;
    busy_cnt = 0;
    start = 1'b1;
    num   = 4'(n);
    gap   = 4'(gv);
    @(posedge clk); #1;
    e0 = int'(cyc);             // cycle k shows cyc == e0 + k - 1
    start = 1'b0;
    n_exp = 0;
    for (int i = 0; i < n; i++) begin
      pc = 1 + i * (g + 1);
      if (cut == 0 || pc <= cut) begin
        exp_q.push_back({1'b0, 1'b1, 16'(e0 + pc - 1), 4'(i), 1'b1});
        n_exp++;
      end
    end
    if (cut == 0) begin
      pc = (n == 0) ? 1 : 2 + (n - 1) * (g + 1);
      exp_q.push_back({1'b1, 1'b0, 16'(e0 + pc - 1), 4'(n), 1'b0});
    end
    timed_out = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      start = (k == sp);
      if (k == sp) begin
        num = 4'd7;
        gap = 4'd0;
      end
      if (cut != 0 && k == cut) begin
        if (cut_abort) begin
`ifdef ABORT_TRAIN_EN
          abort = 1'b1;
`endif
        end else begin
          rst = 1'b0;
        end
      end
      @(posedge clk); #1;
      if (cut != 0 && k == cut) begin
        timed_out = 1'b0;
        break;
      end
      if (cut == 0 && exp_q.size() == 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0;
`ifdef ABORT_TRAIN_EN
    abort = 1'b0;
`endif
    if (timed_out) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got %0d pending events expected 0", exp_q.size());
      exp_q.delete();
    end
    if (cut == 0) begin
      // Now in the mandatory idle cycle after done.
      check("post_inc",   32'(o_inc),  32'd0);
      check("post_busy",  32'(o_busy), 32'd0);
      check("post_done",  32'(o_done), 32'd0);
      check("post_sent",  32'(o_sent), 32'(n));
      check("post_state", 32'(o_dbg_state), 32'd0);
      check("busy_cycles", 32'(busy_cnt),
            (n == 0) ? 32'd0 : 32'((n - 1) * (g + 1) + 1));
    end else begin
      check("cut_inc",   32'(o_inc),  32'd0);
      check("cut_busy",  32'(o_busy), 32'd0);
      check("cut_done",  32'(o_done), 32'd0);
      check("cut_sent",  32'(o_sent), cut_abort ? 32'(n_exp) : 32'd0);
      check("cut_state", 32'(o_dbg_state), 32'd0);
      @(posedge clk); #1;
      check("cut_done2", 32'(o_done), 32'd0);
      check("cut_inc2",  32'(o_inc),  32'd0);
      check("cut_queue", 32'(exp_q.size()), 32'd0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("cut_idle_sent", 32'(o_sent), cut_abort ? 32'(n_exp) : 32'd0);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst   = 1'b0;
    start = 1'b1;
    num   = 4'd3;
    gap   = 4'd2;
`ifdef ABORT_TRAIN_EN
    abort = 1'b0;
`endif
    // Reset held for two cycles with start asserted.
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_inc",   32'(o_inc),  32'd0);
      check("rst_busy",  32'(o_busy), 32'd0);
      check("rst_done",  32'(o_done), 32'd0);
      check("rst_sent",  32'(o_sent), 32'd0);
      check("rst_state", 32'(o_dbg_state), 32'd0);
    end
    rst = 1'b1;
    // Accepted at the first edge with rst released and start still high.
    run_train(3, 2, 0, 0, 1'b0);
    run_train(0, 5, 0, 0, 1'b0);
    run_train(4, 0, 0, 0, 1'b0);
    run_train(15, 1, 10, 0, 1'b0);
    run_train(5, 2, 0, 5, 1'b0);
    run_train(2, 3, 0, 0, 1'b0);
`ifdef ABORT_TRAIN_EN
    run_train(6, 3, 0, 7, 1'b1);
`endif
    run_train(1, 0, 0, 0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
